// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM/sequencer output bundle of the program loader.
interface prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ram_we;
  logic [7:0] ram_adr;
  logic [7:0] ram_data;
  logic       start;
  logic       busy;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;

  modport master (
    output rx_data, rx_valid,
    input  ram_we, ram_adr, ram_data, start, busy, pkt_ok, pkt_err, err_code
  );

  modport slave (
    input  rx_data, rx_valid,
    output ram_we, ram_adr, ram_data, start, busy, pkt_ok, pkt_err, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// Assembles SOF/LEN/payload/CHK frames from the UART byte stream into program RAM
// and kicks the command sequencer with a START_W-cycle start pulse on a good checksum.
//
// state     | meaning
// S_IDLE    | waiting for SOF, all other bytes dropped
// S_LEN     | expecting the payload length byte
// S_PAYLOAD | writing payload bytes to RAM, accumulating checksum
// S_CHK     | expecting the checksum byte
// S_START   | driving start for START_W cycles, input dropped
module prog_loader #(
  parameter logic [7:0] BASE_ADR = 8'd2,
  parameter logic [7:0] MAX_LEN  = 8'd253,
  parameter int         START_W  = 4,
  parameter int         TIMEOUT  = 50000,
  parameter logic [7:0] SOF      = 8'hAA
) (
  input logic           clk,
  input logic           rst_n,
  prog_loader_if.slave  bus
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(START_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_START} state_t;

  state_t        state, state_nxt;
  logic [7:0]    len_q, idx_q, sum_q;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] stt_cnt;

  logic in_pkt, tmo, len_bad, len_good, pay_wr, pay_last, chk_ok, chk_bad;
  logic start_c, busy_c;

  logic       ram_we_q, pkt_ok_q, pkt_err_q;
  logic [7:0] ram_adr_q, ram_data_q;
  logic [1:0] err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.rx_valid && bus.rx_data == SOF) state_nxt = S_LEN;
      S_LEN:     if (len_bad || tmo) state_nxt = S_IDLE;
                 else if (len_good) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (pay_last) state_nxt = S_CHK;
                 else if (tmo) state_nxt = S_IDLE;
      S_CHK:     if (chk_ok) state_nxt = S_START;
                 else if (chk_bad || tmo) state_nxt = S_IDLE;
      S_START:   if (stt_cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // rx_valid takes priority over an expiring gap timer in the same cycle
  always_comb begin
    in_pkt   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    tmo      = in_pkt && !bus.rx_valid && (gap_cnt == '0);
    len_bad  = (state == S_LEN) && bus.rx_valid &&
               ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN));
    len_good = (state == S_LEN) && bus.rx_valid && !len_bad;
    pay_wr   = (state == S_PAYLOAD) && bus.rx_valid;
    pay_last = pay_wr && (idx_q == len_q - 8'd1);
    chk_ok   = (state == S_CHK) && bus.rx_valid && (bus.rx_data == sum_q);
    chk_bad  = (state == S_CHK) && bus.rx_valid && (bus.rx_data != sum_q);
    start_c  = (state == S_START);
    busy_c   = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      gap_cnt    <= GW'(TIMEOUT - 1);
      stt_cnt    <= SW'(START_W - 1);
      ram_we_q   <= 1'b0;
      ram_adr_q  <= '0;
      ram_data_q <= '0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      if (len_good) begin
        len_q <= bus.rx_data;
        sum_q <= bus.rx_data;
        idx_q <= '0;
      end else if (pay_wr) begin
        sum_q <= sum_q + bus.rx_data;
        idx_q <= idx_q + 8'd1;
      end

      if (!in_pkt || bus.rx_valid) gap_cnt <= GW'(TIMEOUT - 1);
      else if (gap_cnt != '0)      gap_cnt <= gap_cnt - 1'b1;

      if (state != S_START) stt_cnt <= SW'(START_W - 1);
      else                  stt_cnt <= stt_cnt - 1'b1;

      ram_we_q   <= pay_wr;
      ram_adr_q  <= pay_wr ? BASE_ADR + idx_q : '0;
      ram_data_q <= pay_wr ? bus.rx_data : '0;
      pkt_ok_q   <= chk_ok;
      pkt_err_q  <= len_bad || chk_bad || tmo;

      if (chk_ok)       err_code_q <= 2'd0;
      else if (len_bad) err_code_q <= 2'd1;
      else if (chk_bad) err_code_q <= 2'd2;
      else if (tmo)     err_code_q <= 2'd3;
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_adr  = ram_adr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.start    = start_c;
  assign bus.busy     = busy_c;
  assign bus.pkt_ok   = pkt_ok_q;
  assign bus.pkt_err  = pkt_err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame parsing, RAM writes, checksum, start pulse, timeout, reset.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int wr_cnt = 0, start_cnt = 0, ok_cnt = 0, err_cnt = 0;

  prog_loader_if bus ();

  prog_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_we)  wr_cnt    <= wr_cnt + 1;
    if (bus.start)   start_cnt <= start_cnt + 1;
    if (bus.pkt_ok)  ok_cnt    <= ok_cnt + 1;
    if (bus.pkt_err) err_cnt   <= err_cnt + 1;
  end

  // Byte is sampled at the posedge in between; returns at the following negedge,
  // where the one-cycle responses to that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_write(input string nm, input logic [7:0] adr, input logic [7:0] dat);
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_adr !== adr || bus.ram_data !== dat) begin
      errors++;
      $display("FAIL %s: got we=%b adr=%h data=%h, expected we=1 adr=%h data=%h",
               nm, bus.ram_we, bus.ram_adr, bus.ram_data, adr, dat);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    checks++;
    if ({bus.ram_we, bus.ram_adr, bus.ram_data, bus.start, bus.busy,
         bus.pkt_ok, bus.pkt_err, bus.err_code} !== 23'd0) begin
      errors++;
      $display("FAIL %s: outputs we=%b adr=%h data=%h start=%b busy=%b ok=%b err=%b code=%0d, expected all 0",
               nm, bus.ram_we, bus.ram_adr, bus.ram_data, bus.start, bus.busy,
               bus.pkt_ok, bus.pkt_err, bus.err_code);
    end
  endtask

  task automatic test_reset();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    chk_all_zero("after_reset_idle");
  endtask

  task automatic test_good_packet();
    int w0, s0, o0;
    w0 = wr_cnt; s0 = start_cnt; o0 = ok_cnt;
    send_byte(8'hAA);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b expected 1", bus.busy); end
    send_byte(8'h03);
    send_byte(8'h30); chk_write("good_w0", 8'd2, 8'h30);
    send_byte(8'h05); chk_write("good_w1", 8'd3, 8'h05);
    send_byte(8'hFE); chk_write("good_w2", 8'd4, 8'hFE);
    send_byte(8'h36);
    checks++;
    if (bus.pkt_ok !== 1'b1 || bus.pkt_err !== 1'b0 || bus.err_code !== 2'd0 || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL good_chk: got ok=%b err=%b code=%0d start=%b, expected ok=1 err=0 code=0 start=1",
               bus.pkt_ok, bus.pkt_err, bus.err_code, bus.start);
    end
    idle_cycles(8);
    checks++;
    if (start_cnt - s0 !== 4) begin errors++; $display("FAIL good_start_width: got %0d cycles expected 4", start_cnt - s0); end
    checks++;
    if (wr_cnt - w0 !== 3 || ok_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL good_counts: got writes=%0d ok=%0d expected writes=3 ok=1", wr_cnt - w0, ok_cnt - o0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_idle: busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_bad_checksum();
    int w0, s0;
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h78); chk_write("badchk_w0", 8'd2, 8'h78);
    send_byte(8'hFE); chk_write("badchk_w1", 8'd3, 8'hFE);
    send_byte(8'h00);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.pkt_ok !== 1'b0 || bus.err_code !== 2'd2) begin
      errors++;
      $display("FAIL badchk_err: got err=%b ok=%b code=%0d expected err=1 ok=0 code=2",
               bus.pkt_err, bus.pkt_ok, bus.err_code);
    end
    idle_cycles(6);
    checks++;
    if (start_cnt - s0 !== 0 || wr_cnt - w0 !== 2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL badchk_after: got start=%0d writes=%0d busy=%b expected start=0 writes=2 busy=0",
               start_cnt - s0, wr_cnt - w0, bus.busy);
    end
  endtask

  task automatic test_length_errors();
    int w0;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h00);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd1) begin
      errors++;
      $display("FAIL len_zero: got err=%b code=%0d expected err=1 code=1", bus.pkt_err, bus.err_code);
    end
    idle_cycles(2);
    send_byte(8'hAA);
    send_byte(8'hFE);
    checks++;
    if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd1) begin
      errors++;
      $display("FAIL len_254: got err=%b code=%0d expected err=1 code=1", bus.pkt_err, bus.err_code);
    end
    idle_cycles(2);
    checks++;
    if (wr_cnt - w0 !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL len_after: got writes=%0d busy=%b expected writes=0 busy=0", wr_cnt - w0, bus.busy);
    end
    // 253 is the largest legal length; the loader must stay in the packet
    send_byte(8'hAA);
    send_byte(8'hFD);
    checks++;
    if (bus.pkt_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL len_253: got err=%b busy=%b expected err=0 busy=1", bus.pkt_err, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("len_253_abort");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11); chk_write("tmo_w0", 8'd2, 8'h11);
    n = 0; seen = 0;
    while (!seen && n < 60000) begin
      @(negedge clk);
      n++;
      if (bus.pkt_err) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tmo_wait: no pkt_err within %0d cycles, expected one near 50000", n);
    end else if (n < 49990 || n > 50010 || bus.err_code !== 2'd3) begin
      errors++;
      $display("FAIL tmo_err: got after %0d cycles code=%0d, expected ~50000 cycles code=3", n, bus.err_code);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.err_code !== 2'd3) begin
      errors++;
      $display("FAIL tmo_idle: got busy=%b code=%0d expected busy=0 code=3", bus.busy, bus.err_code);
    end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h05); chk_write("tmo_recover_w", 8'd2, 8'h05);
    send_byte(8'h06);
    checks++;
    if (bus.pkt_ok !== 1'b1 || bus.err_code !== 2'd0) begin
      errors++;
      $display("FAIL tmo_recover: got ok=%b code=%0d expected ok=1 code=0", bus.pkt_ok, bus.err_code);
    end
    idle_cycles(8);
  endtask

  task automatic test_ignored_bytes();
    int w0, s0;
    w0 = wr_cnt; s0 = start_cnt;
    send_byte(8'h55);
    send_byte(8'h12);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL junk_busy: got %b expected 0", bus.busy); end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hAA); chk_write("sof_in_payload", 8'd2, 8'hAA);
    send_byte(8'hAB);
    checks++;
    if (bus.pkt_ok !== 1'b1 || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL ign_ok: got ok=%b start=%b expected ok=1 start=1", bus.pkt_ok, bus.start);
    end
    send_byte(8'hAA);
    checks++;
    if (bus.ram_we !== 1'b0 || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL ign_during_start: got we=%b start=%b expected we=0 start=1", bus.ram_we, bus.start);
    end
    idle_cycles(8);
    checks++;
    if (wr_cnt - w0 !== 1 || start_cnt - s0 !== 4 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_after: got writes=%0d start=%0d busy=%b expected writes=1 start=4 busy=0",
               wr_cnt - w0, start_cnt - s0, bus.busy);
    end
  endtask

  task automatic test_reset_mid_payload();
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22); chk_write("rst_w1", 8'd3, 8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_payload");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h44); chk_write("rst_recover_w", 8'd2, 8'h44);
    send_byte(8'h45);
    checks++;
    if (bus.pkt_ok !== 1'b1 || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover: got ok=%b start=%b expected ok=1 start=1", bus.pkt_ok, bus.start);
    end
    // reset during the start pulse drops start at once
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_start");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_length_errors();
    test_ignored_bytes();
    test_reset_mid_payload();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
